// File: rtl/down_counter_timer.sv
// down_counter_timer
//   Loadable synchronous down counter used as a programmable interval timer.
//   A load captures load_val into the count and the reload register and starts
//   the timer. Each enabled cycle in RUN decrements the count. Reaching zero
//   raises a one-cycle terminal-count pulse. After that the timer either stops
//   (one-shot) or reloads on the next enabled cycle (auto-reload).
//
// Ports
//   clk      : rising-edge clock
//   reset    : asynchronous, active-high reset
//   load     : capture load_val and start; highest priority
//   load_val : start/reload value (unsigned, WIDTH bits)
//   enable   : count enable
//   mode     : 0 = one-shot, 1 = auto-reload (sampled every cycle)
//   q        : current count (registered)
//   tc       : terminal-count pulse (registered, one cycle)
//   busy     : high while the timer is running
module down_counter_timer #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             enable,
  input  logic             mode,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             tc_q, tc_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      q_q     <= '0;
      rld_q   <= '0;
      tc_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rld_q   <= rld_d;
      tc_q    <= tc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rld_d   = rld_q;
    tc_d    = 1'b0;

    if (load) begin
      q_d     = load_val;
      rld_d   = load_val;
      state_d = (load_val != '0) ? RUN : DONE;
    end else begin
      unique case (state_q)
        RUN: begin
          if (enable) begin
            if (q_q > WIDTH'(1)) begin
              q_d = q_q - WIDTH'(1);
            end else if (q_q == WIDTH'(1)) begin
              q_d  = '0;
              tc_d = 1'b1;
              if (!mode) state_d = DONE;
            end else begin
              // Zero is only seen in RUN after an auto-reload terminal event;
              // the stay-or-stop decision was already made on that edge.
              q_d = rld_q;
            end
          end
        end
        IDLE, DONE: begin
          // Hold; only a load leaves these states.
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign q    = q_q;
  assign tc   = tc_q;
  assign busy = (state_q == RUN);

endmodule

// File: tb/tb_down_counter_timer.sv
module tb_down_counter_timer;

  localparam int unsigned WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             load = 1'b0;
  logic [WIDTH-1:0] load_val = '0;
  logic             enable = 1'b0;
  logic             mode = 1'b0;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             busy;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference timer: plain integers, "running"/"stopped" flags.
  int m_q   = 0;
  int m_rld = 0;
  bit m_running = 0;
  bit m_tc  = 0;

  down_counter_timer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_val),
    .enable   (enable),
    .mode     (mode),
    .q        (q),
    .tc       (tc),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic model_edge(input bit ld, input int val, input bit en, input bit md);
    m_tc = 0;
    if (ld) begin
      m_q = val;
      m_rld = val;
      m_running = (val != 0);
    end else if (m_running && en) begin
      if (m_q == 0) begin
        m_q = m_rld;
      end else begin
        m_q = m_q - 1;
        if (m_q == 0) begin
          m_tc = 1;
          if (!md) m_running = 0;
        end
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".q"}, int'(q), m_q);
    check({tag, ".tc"}, int'(tc), int'(m_tc));
    check({tag, ".busy"}, int'(busy), int'(m_running));
  endtask

  task automatic step(input string tag, input bit ld, input int val, input bit en, input bit md);
    @(negedge clk);
    load = ld;
    load_val = WIDTH'(val);
    enable = en;
    mode = md;
    @(posedge clk);
    model_edge(ld, val, en, md);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    load = 1'b0;
    reset = 1'b1;
    #1;
    m_q = 0; m_rld = 0; m_running = 0; m_tc = 0;
    check({tag, ".q"}, int'(q), 0);
    check({tag, ".tc"}, int'(tc), 0);
    check({tag, ".busy"}, int'(busy), 0);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int exp_q[7];
    bit en_pat[6];
    bit cur_mode;

    reset = 1'b1;
    #1;
    check("reset.q", int'(q), 0);
    check("reset.tc", int'(tc), 0);
    check("reset.busy", int'(busy), 0);
    #3;
    reset = 1'b0;

    // Reset mid-count at q=5, then no counting until a load.
    step("rst_ld", 1, 8, 1, 0);
    for (int i = 0; i < 3; i++) step("rst_cnt", 0, 0, 1, 0);
    check("rst_pre.q", int'(q), 5);
    do_reset("rst_mid");
    for (int i = 0; i < 4; i++) step("rst_idle", 0, 0, 1, 0);

    // One-shot load 3, then hold at 0.
    step("os_ld", 1, 3, 1, 0);
    for (int i = 0; i < 8; i++) step("os_cnt", 0, 0, 1, 0);

    // Auto-reload load 2.
    step("ar_ld", 1, 2, 1, 1);
    for (int i = 0; i < 9; i++) step("ar_cnt", 0, 0, 1, 1);

    // Enable gating, checked against fixed values too.
    exp_q = '{4, 3, 3, 3, 2, 1, 0};
    en_pat = '{1, 0, 0, 1, 1, 1};
    step("eg_ld", 1, 4, 1, 0);
    check("eg_fix.q0", int'(q), exp_q[0]);
    for (int i = 0; i < 6; i++) begin
      step("eg_cnt", 0, 0, en_pat[i], 0);
      check($sformatf("eg_fix.q%0d", i + 1), int'(q), exp_q[i + 1]);
      check($sformatf("eg_fix.tc%0d", i + 1), int'(tc), (i == 5) ? 1 : 0);
    end

    // Reload 9 at the q=1 terminal edge.
    step("lt_ld", 1, 2, 1, 0);
    step("lt_cnt", 0, 0, 1, 0);
    step("lt_rld", 1, 9, 1, 0);
    check("lt_fix.q", int'(q), 9);
    check("lt_fix.tc", int'(tc), 0);
    check("lt_fix.busy", int'(busy), 1);

    // Load 0 and load max.
    step("z_ld", 1, 0, 1, 0);
    for (int i = 0; i < 3; i++) step("z_hold", 0, 0, 1, 0);
    step("m_ld", 1, 15, 1, 0);
    for (int i = 0; i < 18; i++) step("m_cnt", 0, 0, 1, 0);

    // Mode change mid auto-reload count.
    step("mc_ld", 1, 3, 1, 1);
    step("mc_cnt", 0, 0, 1, 1);
    for (int i = 0; i < 6; i++) step("mc_cnt0", 0, 0, 1, 0);

    // Randomized traffic.
    cur_mode = 0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(99) == 0) begin
        do_reset("rnd_rst");
      end else begin
        if ($urandom_range(19) == 0) cur_mode = ~cur_mode;
        step("rnd", ($urandom_range(15) == 0), int'($urandom_range(15)),
             ($urandom_range(3) != 0), cur_mode);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
